sm_add_arb: RTL and testbench

Two-requester arbiter and sequencer wrapped around a sign-magnitude adder datapath. Two clients share one add unit: the block grants one request at a time using round-robin priority, registers the operands, computes the sign-magnitude sum, and returns it with the granted requester's ID over a valid/ready result port. It sits between the operand producers and the downstream consumer of sign-magnitude sums.

---
 rtl/sm_add_arb.sv | 205 ++++++++++++++++++++
 tb/tb_sm_add_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_add_arb.sv
// Two-requester round-robin arbiter feeding a registered sign-magnitude adder.
// Define SM_ADD_OVF_EN to add the res_ovf port (magnitude carry-out of like-sign adds).
module sm_add_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N:0]   req0_a,
    input  logic [N:0]   req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N:0]   req1_a,
    input  logic [N:0]   req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N:0]   res_sum,
    output logic         res_id
`ifdef SM_ADD_OVF_EN
   ,output logic         res_ovf
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic [N:0] op_a_q, op_a_d;
    logic [N:0] op_b_q, op_b_d;
    logic       gnt_id_q, gnt_id_d;
    logic       res_valid_q, res_valid_d;
    logic [N:0] res_sum_q, res_sum_d;
    logic       res_id_q, res_id_d;
`ifdef SM_ADD_OVF_EN
    logic       res_ovf_q, res_ovf_d;
`endif

    // Grant selection. Ready is masked by rst_n so nothing looks accepted while reset holds the flops.
    logic gnt_any;
    logic gnt_sel;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first; a missing path would infer a latch.
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            case ({req1_valid, req0_valid})
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_sel = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_sel = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_sel = prio_q;
                end
                default: begin
                    gnt_any = 1'b0;
                    gnt_sel = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = gnt_any && !gnt_sel;
    assign req1_ready = gnt_any &&  gnt_sel;

    // Sign-magnitude datapath on the captured operands; ties take the sign of b.
    logic [N-1:0] mag_a;
    logic [N-1:0] mag_b;
    logic [N-1:0] mag_max;
    logic [N-1:0] mag_min;
    logic         calc_sign;
    logic         same_sign;
    logic [N:0]   mag_sum;
    logic [N-1:0] mag_diff;
    logic [N-1:0] calc_mag;
    logic         calc_carry;

    always_comb begin
        mag_a     = op_a_q[N-1:0];
        mag_b     = op_b_q[N-1:0];
        same_sign = (op_a_q[N] == op_b_q[N]);
        if (mag_a > mag_b) begin
            mag_max   = mag_a;
            mag_min   = mag_b;
            calc_sign = op_a_q[N];
        end else begin
            mag_max   = mag_b;
            mag_min   = mag_a;
            calc_sign = op_b_q[N];
        end
        mag_sum    = {1'b0, mag_max} + {1'b0, mag_min};
        mag_diff   = mag_max - mag_min;
        calc_mag   = same_sign ? mag_sum[N-1:0] : mag_diff;
        calc_carry = same_sign & mag_sum[N];
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_id_d    = gnt_id_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
`ifdef SM_ADD_OVF_EN
        res_ovf_d   = res_ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    op_a_d   = gnt_sel ? req1_a : req0_a;
                    op_b_d   = gnt_sel ? req1_b : req0_b;
                    gnt_id_d = gnt_sel;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                res_sum_d   = {calc_sign, calc_mag};
                res_id_d    = gnt_id_q;
`ifdef SM_ADD_OVF_EN
                res_ovf_d   = calc_carry;
`endif
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    prio_d      = ~res_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

`ifndef SM_ADD_OVF_EN
    logic unused_carry;
    assign unused_carry = calc_carry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= 1'b0;
`ifdef SM_ADD_OVF_EN
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_id_q    <= gnt_id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
`ifdef SM_ADD_OVF_EN
            res_ovf_q   <= res_ovf_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
`ifdef SM_ADD_OVF_EN
    assign res_ovf   = res_ovf_q;
`endif

    // Protocol invariants the downstream and the requesters rely on.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (req0_ready || req1_ready) |-> (state_q == ST_IDLE));

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_HOLD && !res_ready) |=>
            (res_valid_q && $stable(res_sum_q) && $stable(res_id_q)));

    a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
        state_q != 2'd3);

endmodule

// File: tb/tb_sm_add_arb.sv
// Self-checking bench for sm_add_arb: directed test-plan scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_sm_add_arb;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N:0]   req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_id;
    logic [N:0]   res_sum;
`ifdef SM_ADD_OVF_EN
    logic         res_ovf;
`endif

    always #5 clk = ~clk;

    sm_add_arb #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id)
`ifdef SM_ADD_OVF_EN
       ,.res_ovf    (res_ovf)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic via signed integer values rather than max/min selection.
    task automatic ref_add(input logic [N:0] a, input logic [N:0] b,
                           output logic [N:0] s, output logic o);
        int ma, mb, va, vb, tot, mag;
        logic sg;
        ma = int'(a[N-1:0]);
        mb = int'(b[N-1:0]);
        if (a[N] == b[N]) begin
            tot = ma + mb;
            o   = (tot >= (1 << N));
            mag = tot % (1 << N);
            sg  = a[N];
        end else begin
            va  = a[N] ? -ma : ma;
            vb  = b[N] ? -mb : mb;
            tot = va + vb;
            mag = (tot < 0) ? -tot : tot;
            sg  = (tot > 0) ? 1'b0 : ((tot < 0) ? 1'b1 : b[N]);
            o   = 1'b0;
        end
        s = {sg, N'(mag)};
    endtask

    // Model: busy from accept until consume, result visible two cycles after accept.
    bit         m_busy, m_prio, m_id, m_ovf;
    int         m_vcyc, cyc;
    logic [N:0] m_sum;
    logic       obs_r0, obs_r1, obs_v, obs_id, obs_ovf;
    logic [N:0] obs_sum;

    task automatic step();
        bit e0, e1, ev;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
                e0 = !m_prio;
                e1 = m_prio;
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        ev      = m_busy && (cyc >= m_vcyc);
        obs_r0  = req0_ready;
        obs_r1  = req1_ready;
        obs_v   = res_valid;
        obs_sum = res_sum;
        obs_id  = res_id;
`ifdef SM_ADD_OVF_EN
        obs_ovf = res_ovf;
`else
        obs_ovf = 1'b0;
`endif
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("ready_excl", req0_ready & req1_ready, 1'b0);
        check("res_valid", res_valid, ev);
        if (ev) begin
            check("res_sum", res_sum, m_sum);
            check("res_id", res_id, m_id);
`ifdef SM_ADD_OVF_EN
            check("res_ovf", res_ovf, m_ovf);
`endif
        end
        if (ev && res_ready) begin
            m_busy = 1'b0;
            m_prio = !m_id;
        end
        if (e0 || e1) begin
            m_busy = 1'b1;
            m_vcyc = cyc + 2;
            m_id   = e1;
            ref_add(e1 ? req1_a : req0_a, e1 ? req1_b : req0_b, m_sum, m_ovf);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_prio = 1'b0;
        cyc    = 0;
        m_vcyc = 0;
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Offer one request, wait for accept, then wait for the result; lat counts cycles after accept.
    task automatic run_txn(input bit id, input logic [N:0] a, input logic [N:0] b, output int lat);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!(id ? obs_r1 : obs_r0) && n < 20);
        check("txn_accept", id ? obs_r1 : obs_r0, 1'b1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!obs_v && lat < 20);
    endtask

    task automatic drain();
        res_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, n;
        int ids[$];
        logic [N:0] s0;
        logic       i0;

        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_sum", res_sum, '0);
        check("rst_res_id", res_id, 1'b0);
`ifdef SM_ADD_OVF_EN
        check("rst_res_ovf", res_ovf, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Mixed signs, single request.
        res_ready = 1'b1;
        run_txn(1'b0, 5'b0_0011, 5'b1_0101, lat);
        check("mixed_latency", lat, 2);
        check("mixed_sum", obs_sum, 5'b1_0010);
        check("mixed_id", obs_id, 1'b0);
        drain();

        // Overflow.
        run_txn(1'b1, 5'b0_0111, 5'b0_1001, lat);
        check("ovf_sum", obs_sum, 5'b0_0000);
        check("ovf_id", obs_id, 1'b1);
`ifdef SM_ADD_OVF_EN
        check("ovf_flag", obs_ovf, 1'b1);
`endif
        drain();

        // Tie with opposite signs.
        run_txn(1'b0, 5'b0_0100, 5'b1_0100, lat);
        check("tie_sum", obs_sum, 5'b1_0000);
        drain();

        // Contention from reset.
        apply_reset();
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = N'($urandom) + 0; req0_b = (N+1)'($urandom);
        req1_valid = 1'b1; req1_a = (N+1)'($urandom); req1_b = (N+1)'($urandom);
        n = 0;
        while (ids.size() < 4 && n < 60) begin
            step();
            n++;
            if (obs_v) ids.push_back(int'(obs_id));
            if (obs_r0) begin req0_a = (N+1)'($urandom); req0_b = (N+1)'($urandom); end
            if (obs_r1) begin req1_a = (N+1)'($urandom); req1_b = (N+1)'($urandom); end
        end
        check("contend_count", ids.size(), 4);
        foreach (ids[i]) check("contend_order", ids[i], i % 2);
        drain();

        // Back-pressure in HOLD; req1 rises during HOLD.
        res_ready = 1'b0;
        run_txn(1'b0, (N+1)'($urandom), (N+1)'($urandom), lat);
        s0 = obs_sum;
        i0 = obs_id;
        req1_valid = 1'b1; req1_a = (N+1)'($urandom); req1_b = (N+1)'($urandom);
        repeat (5) begin
            step();
            check("bp_valid", obs_v, 1'b1);
            check("bp_sum", obs_sum, s0);
            check("bp_id", obs_id, i0);
            check("bp_ready", obs_r0 | obs_r1, 1'b0);
        end
        res_ready = 1'b1;
        step();
        step();
        check("bp_next_grant", obs_r1, 1'b1);
        req1_valid = 1'b0;
        drain();

        // Reset in HOLD: make prio point at requester 1 first so the cleared pointer is observable.
        run_txn(1'b0, (N+1)'($urandom), (N+1)'($urandom), lat);
        drain();
        res_ready  = 1'b0;
        req0_valid = 1'b1; req0_a = (N+1)'($urandom); req0_b = (N+1)'($urandom);
        req1_valid = 1'b1; req1_a = (N+1)'($urandom); req1_b = (N+1)'($urandom);
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_v && n < 10);
        check("hold_reached", obs_v, 1'b1);
        check("hold_grant_id", obs_id, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res_valid", res_valid, 1'b0);
        check("arst_res_sum", res_sum, '0);
        check("arst_res_id", res_id, 1'b0);
        check("arst_ready", req0_ready | req1_ready, 1'b0);
`ifdef SM_ADD_OVF_EN
        check("arst_res_ovf", res_ovf, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_next_grant", obs_r0, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Randomized traffic; requesters hold valid and operands until accepted.
        for (int k = 0; k < 600; k++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid || obs_r0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = (N+1)'($urandom);
                req0_b = (N+1)'($urandom);
            end
            if (!req1_valid || obs_r1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = (N+1)'($urandom);
                req1_b = (N+1)'($urandom);
            end
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
